// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter for CLIENTS requesters sharing one resource.
//
// grant is a combinational function of request and the priority pointer ptr_q.
// The client at ptr_q has the highest priority. The scan runs upward from
// ptr_q and wraps from CLIENTS-1 back to 0. After a grant to client k, the
// pointer moves to k+1 so that the winner drops to lowest priority. While
// stall is high the pointer is frozen, but the grant is still produced.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   asynchronous active-low reset; while low, grant is all-zero
//   request in   [CLIENTS-1:0] one bit per requesting client
//   stall   in   1 = hold the priority pointer (resource busy)
//   grant   out  [CLIENTS-1:0] one-hot or zero, always a subset of request
//
// Optional: define RR_ARBITER_ASSERT_EN to compile internal concurrent checks
// (one-hot grant, grant within request, pointer frozen under stall, bounded
// wait for held requests). Functional behaviour is the same either way.
module rr_arbiter #(
    parameter int CLIENTS = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CLIENTS-1:0] request,
    input  logic               stall,
    output logic [CLIENTS-1:0] grant
);
    localparam int PW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic [CLIENTS-1:0] masked;
    logic [PW-1:0]      win_hi, win_lo, win;
    logic               hit_hi, hit_lo;

    // Two-encoder scheme. The masked encoder only sees clients at or above
    // ptr_q. If that set is empty, the scan has wrapped, and the lowest
    // requester overall wins.
    always_comb begin
        masked = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            masked[i] = request[i] && (i >= int'(ptr_q));
        end

        hit_hi = 1'b0;
        win_hi = '0;
        hit_lo = 1'b0;
        win_lo = '0;
        // The descending loop leaves the lowest set index as the winner.
        for (int i = CLIENTS - 1; i >= 0; i--) begin
            if (masked[i]) begin
                hit_hi = 1'b1;
                win_hi = PW'(i);
            end
            if (request[i]) begin
                hit_lo = 1'b1;
                win_lo = PW'(i);
            end
        end
        win = hit_hi ? win_hi : win_lo;

        grant = '0;
        if (reset && hit_lo) begin
            grant[win] = 1'b1;
        end

        ptr_d = ptr_q;
        if (!stall && hit_lo) begin
            ptr_d = (win == PW'(CLIENTS - 1)) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

`ifdef RR_ARBITER_ASSERT_EN
    a_onehot: assert property (@(posedge clock) disable iff (!reset)
        $onehot0(grant));
    a_subset: assert property (@(posedge clock) disable iff (!reset)
        (grant & ~request) == '0);
    a_stall: assert property (@(posedge clock) disable iff (!reset)
        stall |=> $stable(ptr_q));

    // Per-client count of consecutive cycles spent requesting without a grant
    // while not stalled. A held request must win by the time this count
    // reaches CLIENTS-1.
    logic [CLIENTS-1:0][PW:0] wait_q, wait_d;

    always_comb begin
        wait_d = '0;
        for (int i = 0; i < CLIENTS; i++) begin
            if (request[i] && !grant[i] && !stall) begin
                wait_d[i] = (wait_q[i] == (PW+1)'(CLIENTS - 1)) ? wait_q[i] : wait_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end

    for (genvar g = 0; g < CLIENTS; g++) begin : g_fair
        a_fair: assert property (@(posedge clock) disable iff (!reset)
            !(request[g] && !grant[g] && !stall && wait_q[g] >= (PW+1)'(CLIENTS - 1)));
    end
`endif

endmodule

// File: tb/tb_rr_arbiter.sv
module tb_rr_arbiter;
    localparam int N = 32;

    logic         clock;
    logic         reset;
    logic [N-1:0] request;
    logic         stall;
    logic [N-1:0] grant;

    int errors = 0;
    int checks = 0;
    int mptr   = 0;   // model priority pointer
    bit run_cmp = 1'b0;

    rr_arbiter #(.CLIENTS(N)) dut (
        .clock  (clock),
        .reset  (reset),
        .request(request),
        .stall  (stall),
        .grant  (grant)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: walk the clients starting at p and wrapping; the first requester wins.
    function automatic int model_win(logic [N-1:0] r, int p);
        for (int j = 0; j < N; j++) begin
            int idx;
            idx = (p + j) % N;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_grant(logic [N-1:0] r, int p, logic rs);
        logic [N-1:0] g;
        int w;
        g = '0;
        w = model_win(r, p);
        if (rs && w >= 0) g[w] = 1'b1;
        return g;
    endfunction

    // Model pointer update.
    initial begin
        forever begin
            @(posedge clock or negedge reset);
            if (!reset) begin
                mptr = 0;
            end else if (!stall && model_win(request, mptr) >= 0) begin
                mptr = (model_win(request, mptr) + 1) % N;
            end
        end
    end

    task automatic chk(string nm, logic [N-1:0] act, logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_int(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, at the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            if (run_cmp) chk("model", grant, model_grant(request, mptr, reset));
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reset for one edge and leave the bench at posedge+1 with reset released.
    task automatic do_reset();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int cnt[N];
        int hit;
        reset   = 1'b0;
        request = '1;
        stall   = 1'b0;
        run_cmp = 1'b1;

        // Reset: grant is held at zero while reset is low.
        step();
        step();
        chk("reset_grant_zero", grant, '0);
        chk_int("reset_model_ptr", mptr, 0);
        reset = 1'b1;
        #1;
        chk("release_grant0", grant, 32'h1);
        step();
        chk("next_grant1", grant, 32'h2);

        // Single client.
        do_reset();
        request = 32'h10;
        #1;
        chk("single_comb", grant, 32'h10);
        step();
        chk_int("single_model_ptr5", mptr, 5);
        chk("single_held", grant, 32'h10);

        // All clients requesting: the grant walks through the clients in order.
        do_reset();
        request = '1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 34; c++) begin
            logic [N-1:0] e;
            #1;
            e = '0;
            e[c % N] = 1'b1;
            chk("walk", grant, e);
            if (c < N) begin
                for (int i = 0; i < N; i++) if (grant[i]) cnt[i]++;
            end
            step();
        end
        for (int i = 0; i < N; i++) chk_int("once_per_round", cnt[i], 1);

        // Fairness bound: ptr=5, client 4 is granted at offset 31.
        do_reset();
        request = 32'h10;
        step();
        request = '1;
        hit = -1;
        for (int c = 0; c < 40 && hit < 0; c++) begin
            #1;
            if (grant[4]) hit = c;
            else step();
        end
        chk_int("fair_offset", hit, 31);

        // Stall: ptr=4, so client 4 keeps the grant while the pointer is frozen.
        do_reset();
        request = 32'h8;
        step();
        request = 32'h30;
        stall   = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("stall_hold", grant, 32'h10);
            step();
        end
        stall = 1'b0;
        #1;
        chk("unstall_same", grant, 32'h10);
        step();
        chk("unstall_next", grant, 32'h20);

        // Mid-operation reset.
        do_reset();
        request = 32'h8000_0000;
        #1;
        chk("top_client", grant, 32'h8000_0000);
        step();
        chk("top_held", grant, 32'h8000_0000);
        reset   = 1'b0;
        request = 32'h8000_0006;
        #1;
        chk("mid_reset_zero", grant, '0);
        step();
        reset = 1'b1;
        #1;
        chk("post_reset_low", grant, 32'h2);
        chk_int("post_reset_mptr", mptr, 0);
        step();
        chk("post_reset_next", grant, 32'h4);

        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
